instruction_decompose: RTL and testbench



---
 rtl/instruction_decompose_pkg.sv | 77 +++++++
 rtl/instruction_decompose_operand_select.sv | 31 +++
 rtl/instruction_decompose.sv | 175 +++++++++++++++++
 tb/tb_instruction_decompose.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/instruction_decompose_pkg.sv
// Shared decode definitions: opcodes, ALU op encoding, decomposed-entry layout.
package decode_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

   typedef enum logic [5:0] {
      OP_ADD    = 6'd0,
      OP_SUB    = 6'd1,
      OP_SLL    = 6'd2,
      OP_SLT    = 6'd3,
      OP_SLTU   = 6'd4,
      OP_XOR    = 6'd5,
      OP_SRL    = 6'd6,
      OP_SRA    = 6'd7,
      OP_OR     = 6'd8,
      OP_AND    = 6'd9,
      OP_MUL    = 6'd16,
      OP_MULH   = 6'd17,
      OP_MULHSU = 6'd18,
      OP_MULHU  = 6'd19,
      OP_DIV    = 6'd20,
      OP_DIVU   = 6'd21,
      OP_REM    = 6'd22,
      OP_REMU   = 6'd23
   } alu_op_e;

   localparam int unsigned DI_W         = 83;
   localparam int unsigned DI_OP_LSB    = 77;
   localparam int unsigned DI_OPND1_LSB = 45;
   localparam int unsigned DI_OPND2_LSB = 13;
   localparam int unsigned DI_RDY1      = 12;
   localparam int unsigned DI_RDY2      = 11;
   localparam int unsigned DI_TAG1_LSB  = 6;
   localparam int unsigned DI_TAG2_LSB  = 1;
   localparam int unsigned DI_WB        = 0;

   // funct3 -> ALU op for the base integer group (funct7 = 0000000)
   function automatic alu_op_e base_op(input logic [2:0] f3);
      case (f3)
         3'b000:  return OP_ADD;
         3'b001:  return OP_SLL;
         3'b010:  return OP_SLT;
         3'b011:  return OP_SLTU;
         3'b100:  return OP_XOR;
         3'b101:  return OP_SRL;
         3'b110:  return OP_OR;
         default: return OP_AND;
      endcase
   endfunction

   function automatic logic [DI_W-1:0] pack_entry(
      input alu_op_e     op,
      input logic [31:0] opnd1,
      input logic [31:0] opnd2,
      input logic        rdy1,
      input logic        rdy2,
      input logic [4:0]  tag1,
      input logic [4:0]  tag2,
      input logic        wb
   );
      logic [DI_W-1:0] e;
      e = '0;
      e[DI_OP_LSB    +: 6]  = op;
      e[DI_OPND1_LSB +: 32] = opnd1;
      e[DI_OPND2_LSB +: 32] = opnd2;
      e[DI_RDY1]            = rdy1;
      e[DI_RDY2]            = rdy2;
      e[DI_TAG1_LSB  +: 5]  = tag1;
      e[DI_TAG2_LSB  +: 5]  = tag2;
      e[DI_WB]              = wb;
      return e;
   endfunction

endpackage

// File: rtl/instruction_decompose_operand_select.sv
// Resolves one register source: x0, committed regfile value, forwarding bus, or wait on tag.
module operand_select
   import decode_pkg::*;
(
   input  logic [4:0]  addr_i,
   input  logic [31:0] reg_val_i,
   input  logic        valid_i,
   input  logic [31:0] fwd_i,
   input  logic [4:0]  fwd_addr_i,
   output logic [31:0] value_o,
   output logic        ready_o,
   output logic [4:0]  tag_o
);

   // Regfile data wins over the forwarding bus; an unresolved source waits on its tag.
   always_comb begin
      value_o = '0;
      ready_o = 1'b0;
      tag_o   = addr_i;
      if (addr_i == 5'd0) begin
         ready_o = 1'b1;
      end else if (valid_i) begin
         value_o = reg_val_i;
         ready_o = 1'b1;
      end else if (fwd_addr_i == addr_i) begin
         value_o = fwd_i;
         ready_o = 1'b1;
      end
   end

endmodule

// File: rtl/instruction_decompose.sv
// Decode stage: splits one RV32IM instruction into a registered rename/RS entry.
module instruction_decompose
   import decode_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic [31:0]   inst,
   input  logic [31:0]   s1,
   input  logic [31:0]   s2,
   input  logic          rs1_valid,
   input  logic          rs2_valid,
   input  logic [31:0]   pc,
   input  logic [31:0]   forwarding,
   input  logic [4:0]    forwarding_addr,
   output logic          map_en,
   output logic [4:0]    rs1,
   output logic [4:0]    rs2,
   output logic [4:0]    rd,
   output logic [82:0]   decomposed_inst,
   output logic          error
);

   logic [6:0]      opcode;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [31:0]     v1, v2;
   logic            r1, r2;
   logic [4:0]      t1, t2;
   logic            legal;
   alu_op_e         op;
   logic [31:0]     opnd1, opnd2;
   logic            rdy1, rdy2;

   logic            map_en_d, map_en_q;
   logic [4:0]      rd_d, rd_q;
   logic [DI_W-1:0] entry_d, entry_q;
   logic            error_d, error_q;

   assign opcode = inst[6:0];
   assign f3     = inst[14:12];
   assign f7     = inst[31:25];

   // Source read addresses; unused sources read x0 so their tags also come out 0.
   always_comb begin
      rs1 = inst[19:15];
      rs2 = inst[24:20];
      if (opcode == OPC_LUI || opcode == OPC_AUIPC) begin
         rs1 = '0;
         rs2 = '0;
      end else if (opcode == OPC_OP_IMM) begin
         rs2 = '0;
      end
   end

   operand_select u_sel1 (
      .addr_i     (rs1),
      .reg_val_i  (s1),
      .valid_i    (rs1_valid),
      .fwd_i      (forwarding),
      .fwd_addr_i (forwarding_addr),
      .value_o    (v1),
      .ready_o    (r1),
      .tag_o      (t1)
   );

   operand_select u_sel2 (
      .addr_i     (rs2),
      .reg_val_i  (s2),
      .valid_i    (rs2_valid),
      .fwd_i      (forwarding),
      .fwd_addr_i (forwarding_addr),
      .value_o    (v2),
      .ready_o    (r2),
      .tag_o      (t2)
   );

   // Opcode/funct decode into ALU op and operand sources.
   always_comb begin
      legal = 1'b0;
      op    = OP_ADD;
      opnd1 = v1;
      opnd2 = v2;
      rdy1  = r1;
      rdy2  = r2;
      case (opcode)
         OPC_OP: begin
            case (f7)
               7'b0000000: begin
                  legal = 1'b1;
                  op    = base_op(f3);
               end
               7'b0100000: begin
                  if (f3 == 3'b000) begin
                     legal = 1'b1;
                     op    = OP_SUB;
                  end else if (f3 == 3'b101) begin
                     legal = 1'b1;
                     op    = OP_SRA;
                  end
               end
               7'b0000001: begin
                  legal = 1'b1;
                  op    = alu_op_e'({3'b010, f3});
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_OP_IMM: begin
            opnd2 = {{20{inst[31]}}, inst[31:20]};
            rdy2  = 1'b1;
            case (f3)
               3'b001: begin
                  opnd2 = {27'd0, inst[24:20]};
                  if (f7 == 7'b0000000) begin
                     legal = 1'b1;
                     op    = OP_SLL;
                  end
               end
               3'b101: begin
                  opnd2 = {27'd0, inst[24:20]};
                  if (f7 == 7'b0000000) begin
                     legal = 1'b1;
                     op    = OP_SRL;
                  end else if (f7 == 7'b0100000) begin
                     legal = 1'b1;
                     op    = OP_SRA;
                  end
               end
               default: begin
                  legal = 1'b1;
                  op    = base_op(f3);
               end
            endcase
         end
         OPC_LUI, OPC_AUIPC: begin
            legal = 1'b1;
            op    = OP_ADD;
            opnd1 = (opcode == OPC_AUIPC) ? pc : '0;
            opnd2 = {inst[31:12], 12'd0};
            rdy1  = 1'b1;
            rdy2  = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   // Next-state values; an illegal instruction produces an all-zero entry.
   always_comb begin
      entry_d  = legal ? pack_entry(op, opnd1, opnd2, rdy1, rdy2, t1, t2, 1'b1) : '0;
      rd_d     = legal ? inst[11:7] : '0;
      map_en_d = legal && (inst[11:7] != 5'd0);
      error_d  = !legal;
   end

   // Output register stage, one-cycle latency.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         map_en_q <= 1'b0;
         rd_q     <= '0;
         entry_q  <= '0;
         error_q  <= 1'b0;
      end else begin
         map_en_q <= map_en_d;
         rd_q     <= rd_d;
         entry_q  <= entry_d;
         error_q  <= error_d;
      end
   end

   assign map_en          = map_en_q;
   assign rd              = rd_q;
   assign decomposed_inst = entry_q;
   assign error           = error_q;

endmodule

// File: tb/tb_instruction_decompose.sv
// Directed bench for instruction_decompose with hand-computed expected entries.
module tb_instruction_decompose;

   localparam logic [6:0] OP  = 7'b0110011;
   localparam logic [6:0] IMM = 7'b0010011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst, s1, s2, pc, forwarding;
   logic        rs1_valid, rs2_valid;
   logic [4:0]  forwarding_addr;
   logic        map_en, error;
   logic [4:0]  rs1, rs2, rd;
   logic [82:0] decomposed_inst;

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   instruction_decompose dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .inst            (inst),
      .s1              (s1),
      .s2              (s2),
      .rs1_valid       (rs1_valid),
      .rs2_valid       (rs2_valid),
      .pc              (pc),
      .forwarding      (forwarding),
      .forwarding_addr (forwarding_addr),
      .map_en          (map_en),
      .rs1             (rs1),
      .rs2             (rs2),
      .rd              (rd),
      .decomposed_inst (decomposed_inst),
      .error           (error)
   );

   function automatic logic [82:0] mk(input logic [5:0] op, input logic [31:0] o1,
                                      input logic [31:0] o2, input logic r1, input logic r2,
                                      input logic [4:0] t1, input logic [4:0] t2, input logic wb);
      return {op, o1, o2, r1, r2, t1, t2, wb};
   endfunction

   task automatic chk(input string tag, input logic [82:0] obs, input logic [82:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [82:0] e, input logic [4:0] erd,
                          input logic emap, input logic eerr);
      chk({tag, ".entry"}, decomposed_inst, e);
      chk({tag, ".rd"}, rd, erd);
      chk({tag, ".map_en"}, map_en, emap);
      chk({tag, ".error"}, error, eerr);
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic va,
                        input logic [31:0] b, input logic vb,
                        input logic [31:0] f, input logic [4:0] fa);
      inst = i; s1 = a; rs1_valid = va; s2 = b; rs2_valid = vb;
      forwarding = f; forwarding_addr = fa;
   endtask

   initial begin
      rst_n = 1'b0;
      pc    = '0;
      drive('0, '0, 1'b0, '0, 1'b0, '0, '0);
      #12;
      chk_out("reset", '0, 5'd0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // add x3,x1,x2
      drive(32'h002081B3, 32'd2, 1'b1, 32'd1, 1'b1, 32'd0, 5'd0);
      #1;
      chk("add.rs1", rs1, 5'd1);
      chk("add.rs2", rs2, 5'd2);
      tick();
      chk_out("add", mk(6'd0, 32'd2, 32'd1, 1, 1, 5'd1, 5'd2, 1), 5'd3, 1'b1, 1'b0);

      // mul x6,x4,x5 with rs2 supplied by forwarding
      drive({7'b0000001, 5'd5, 5'd4, 3'b000, 5'd6, OP}, 32'd7, 1'b1, 32'hDEAD, 1'b0, 32'd5, 5'd5);
      tick();
      chk_out("mul", mk(6'd16, 32'd7, 32'd5, 1, 1, 5'd4, 5'd5, 1), 5'd6, 1'b1, 1'b0);

      // slli x3,x1,2 with rs1 unresolved
      drive({7'b0000000, 5'd2, 5'd1, 3'b001, 5'd3, IMM}, 32'd123, 1'b0, 32'd0, 1'b1, 32'd77, 5'd0);
      #1;
      chk("slli.rs1", rs1, 5'd1);
      chk("slli.rs2", rs2, 5'd0);
      tick();
      chk_out("slli", mk(6'd2, 32'd0, 32'd2, 0, 1, 5'd1, 5'd0, 1), 5'd3, 1'b1, 1'b0);

      // addi x3,x1,-30
      drive({12'hFE2, 5'd1, 3'b000, 5'd3, IMM}, 32'd9, 1'b1, 32'd0, 1'b0, 32'd0, 5'd0);
      tick();
      chk_out("addi", mk(6'd0, 32'd9, 32'hFFFFFFE2, 1, 1, 5'd1, 5'd0, 1), 5'd3, 1'b1, 1'b0);

      // sub x3,x1,x2, neither source available
      drive({7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, OP}, 32'd4, 1'b0, 32'd8, 1'b0, 32'd66, 5'd7);
      tick();
      chk_out("sub", mk(6'd1, 32'd0, 32'd0, 0, 0, 5'd1, 5'd2, 1), 5'd3, 1'b1, 1'b0);

      // regfile value beats a matching forward; rs2 forward address mismatch
      drive(32'h002081B3, 32'hAA, 1'b1, 32'd3, 1'b0, 32'hBB, 5'd1);
      tick();
      chk_out("prio", mk(6'd0, 32'hAA, 32'd0, 1, 0, 5'd1, 5'd2, 1), 5'd3, 1'b1, 1'b0);

      // add x3,x0,x2: x0 source is ready zero regardless of valid/s1
      drive({7'b0000000, 5'd2, 5'd0, 3'b000, 5'd3, OP}, 32'hDEAD, 1'b0, 32'd4, 1'b1, 32'd99, 5'd0);
      tick();
      chk_out("x0src", mk(6'd0, 32'd0, 32'd4, 1, 1, 5'd0, 5'd2, 1), 5'd3, 1'b1, 1'b0);

      // srai x3,x1,31
      drive({7'b0100000, 5'd31, 5'd1, 3'b101, 5'd3, IMM}, 32'h80000000, 1'b1, 32'd0, 1'b0, 32'd0, 5'd0);
      tick();
      chk_out("srai", mk(6'd7, 32'h80000000, 32'd31, 1, 1, 5'd1, 5'd0, 1), 5'd3, 1'b1, 1'b0);

      // remu x3,x1,x2
      drive({7'b0000001, 5'd2, 5'd1, 3'b111, 5'd3, OP}, 32'd10, 1'b1, 32'd3, 1'b1, 32'd0, 5'd0);
      tick();
      chk_out("remu", mk(6'd23, 32'd10, 32'd3, 1, 1, 5'd1, 5'd2, 1), 5'd3, 1'b1, 1'b0);

      // opcode 0000000
      drive({7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0000000}, 32'd1, 1'b1, 32'd2, 1'b1, 32'd0, 5'd0);
      tick();
      chk_out("badopc", '0, 5'd0, 1'b0, 1'b1);

      // OP funct7=0100000 funct3=001 is not defined
      drive({7'b0100000, 5'd2, 5'd1, 3'b001, 5'd3, OP}, 32'd1, 1'b1, 32'd2, 1'b1, 32'd0, 5'd0);
      tick();
      chk_out("badf7op", '0, 5'd0, 1'b0, 1'b1);

      // slli with funct7=0100000 is not defined
      drive({7'b0100000, 5'd2, 5'd1, 3'b001, 5'd3, IMM}, 32'd1, 1'b1, 32'd2, 1'b1, 32'd0, 5'd0);
      tick();
      chk_out("badslli", '0, 5'd0, 1'b0, 1'b1);

      // lui x3,0x0020F (raw rs1 field is 1, must read as 0)
      drive({20'h0020F, 5'd3, 7'b0110111}, 32'd5, 1'b1, 32'd6, 1'b1, 32'd0, 5'd0);
      #1;
      chk("lui.rs1", rs1, 5'd0);
      chk("lui.rs2", rs2, 5'd0);
      tick();
      chk_out("lui", mk(6'd0, 32'd0, 32'h0020F000, 1, 1, 5'd0, 5'd0, 1), 5'd3, 1'b1, 1'b0);

      // auipc x5,0x1 at pc 0x1000
      pc = 32'h00001000;
      drive({20'h00001, 5'd5, 7'b0010111}, 32'd5, 1'b1, 32'd6, 1'b1, 32'd0, 5'd0);
      tick();
      chk_out("auipc", mk(6'd0, 32'h1000, 32'h1000, 1, 1, 5'd0, 5'd0, 1), 5'd5, 1'b1, 1'b0);

      // asynchronous reset between edges
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("async_rst", '0, 5'd0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // add x0,x1,x2: legal but no rename mapping
      drive({7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0, OP}, 32'd1, 1'b1, 32'd2, 1'b1, 32'd0, 5'd0);
      tick();
      chk_out("rd_x0", mk(6'd0, 32'd1, 32'd2, 1, 1, 5'd1, 5'd2, 1), 5'd0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
